mem_fill_arbiter: RTL and testbench

- Controller/arbiter for the single shared multi-cycle main memory in the cached pipeline.
- Serves three requesters: D-side write-through stores, D-cache miss fills and I-cache miss fills.
- Sequences 8-word block fills over the pipelined memory and steers returned words into the granted cache.
- Sits between the I/D caches (and their miss stalls) and the main memory instance.

---
 rtl/mem_fill_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mem_fill_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_fill_arbiter.sv
// Arbitrates the shared main memory between write-through stores and
// I/D block fills; sequences 8-word fills and steers words to the caches.
// Ports: clk, rst (sync, active-high); i/d miss request+address, d store
// request/address/data and ack; mem_* memory command and return path;
// fill_data/fill_idx/{i,d}_fill_we cache write port; {i,d}_fill_done; busy.
// Option: define MEM_ARB_RR_EN for round-robin between I and D fills.
module mem_fill_arbiter #(
  parameter int ADDR_W        = 16,
  parameter int WORDS_PER_BLK = 8,
  parameter int IDX_W         = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_miss_req,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss_req,
  input  logic [ADDR_W-1:0] d_miss_addr,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [15:0]       d_wr_data,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_data_valid,
  input  logic [15:0]       mem_rdata,
  output logic [15:0]       fill_data,
  output logic [IDX_W-1:0]  fill_idx,
  output logic              i_fill_we,
  output logic              d_fill_we,
  output logic              i_fill_done,
  output logic              d_fill_done,
  output logic              d_wr_ack,
  output logic              busy
);

  localparam int BLK_W = ADDR_W - IDX_W - 1;
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    G_NONE,
    G_I,
    G_D,
    G_W
  } grant_t;

  state_t           state, state_n;
  grant_t           grant, grant_n;
  grant_t           win;
  logic [BLK_W-1:0] blk_addr, blk_n;
  logic [IDX_W-1:0] issue_cnt, issue_n;
  logic [CNT_W-1:0] recv_cnt, recv_n;
  logic             d_first;
  logic             rx;
  logic             last8;

  // Byte-in-block bits of miss addresses never matter.
  logic unused_lsb;
  assign unused_lsb = ^{i_miss_addr[IDX_W:0], d_miss_addr[IDX_W:0]};

`ifdef MEM_ARB_RR_EN
  // 1 = D was granted the most recent fill; a tie goes to the other side.
  logic last_fill;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_fill <= 1'b0;
    end else if (state == S_IDLE) begin
      if (win == G_D) last_fill <= 1'b1;
      else if (win == G_I) last_fill <= 1'b0;
    end
  end

  assign d_first = ~last_fill;
`else
  assign d_first = 1'b1;
`endif

  always_comb begin
    win = G_NONE;
    if (d_wr_req) win = G_W;
    else if (d_miss_req && i_miss_req) win = d_first ? G_D : G_I;
    else if (d_miss_req) win = G_D;
    else if (i_miss_req) win = G_I;
  end

  // Returns are counted as they arrive, whatever the memory latency.
  assign rx = mem_data_valid &&
              (state == S_ISSUE || state == S_DRAIN);
  assign last8 = rx &&
                 (recv_cnt == CNT_W'(WORDS_PER_BLK - 1));

  assign fill_data = mem_rdata;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      grant     <= G_NONE;
      blk_addr  <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      blk_addr  <= blk_n;
      issue_cnt <= issue_n;
      recv_cnt  <= recv_n;
    end
  end

  always_comb begin
    state_n     = state;
    grant_n     = grant;
    blk_n       = blk_addr;
    issue_n     = issue_cnt;
    recv_n      = recv_cnt;
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    fill_idx    = recv_cnt[IDX_W-1:0];
    i_fill_we   = 1'b0;
    d_fill_we   = 1'b0;
    i_fill_done = 1'b0;
    d_fill_done = 1'b0;
    d_wr_ack    = 1'b0;

    if (rx) begin
      recv_n    = recv_cnt + 1'b1;
      i_fill_we = (grant == G_I);
      d_fill_we = (grant == G_D);
    end

    unique case (state)
      S_IDLE: begin
        grant_n = win;
        if (win == G_W) begin
          state_n = S_WRITE;
        end else if (win == G_D) begin
          blk_n   = d_miss_addr[ADDR_W-1:IDX_W+1];
          state_n = S_ISSUE;
        end else if (win == G_I) begin
          blk_n   = i_miss_addr[ADDR_W-1:IDX_W+1];
          state_n = S_ISSUE;
        end
      end
      S_WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = d_wr_addr;
        mem_wdata = d_wr_data;
        d_wr_ack  = 1'b1;
        grant_n   = G_NONE;
        state_n   = S_IDLE;
      end
      S_ISSUE: begin
        mem_en   = 1'b1;
        mem_addr = {blk_addr, issue_cnt, 1'b0};
        issue_n  = issue_cnt + 1'b1;
        if (issue_cnt == IDX_W'(WORDS_PER_BLK - 1))
          state_n = last8 ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        if (last8) state_n = S_DONE;
      end
      S_DONE: begin
        i_fill_done = (grant == G_I);
        d_fill_done = (grant == G_D);
        issue_n     = '0;
        recv_n      = '0;
        grant_n     = G_NONE;
        state_n     = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
        grant_n = G_NONE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Self-checking bench for mem_fill_arbiter: in-order pipelined memory
// model, per-cycle output log, and a request-level service-order model.
module tb_mem_fill_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_miss_req = 1'b0;
  logic [15:0] i_miss_addr = '0;
  logic        d_miss_req = 1'b0;
  logic [15:0] d_miss_addr = '0;
  logic        d_wr_req = 1'b0;
  logic [15:0] d_wr_addr = '0;
  logic [15:0] d_wr_data = '0;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_data_valid = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic [15:0] fill_data;
  logic [2:0]  fill_idx;
  logic        i_fill_we, d_fill_we;
  logic        i_fill_done, d_fill_done;
  logic        d_wr_ack, busy;

  mem_fill_arbiter dut (
    .clk(clk), .rst(rst),
    .i_miss_req(i_miss_req), .i_miss_addr(i_miss_addr),
    .d_miss_req(d_miss_req), .d_miss_addr(d_miss_addr),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr),
    .d_wr_data(d_wr_data),
    .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_data_valid(mem_data_valid), .mem_rdata(mem_rdata),
    .fill_data(fill_data), .fill_idx(fill_idx),
    .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
    .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
    .d_wr_ack(d_wr_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  localparam int NLOG = 8192;

  int nassert = 0;
  int nfail   = 0;
  int cyc     = 0;
  int lat_min = 4;
  int lat_max = 4;
  int spur_at = -1;
  int last_rc = 0;
  bit last_d  = 1'b0;

  typedef struct {
    int          rc;
    logic [15:0] a;
  } rd_t;
  rd_t pend[$];

  bit        log_en    [0:NLOG-1];
  bit        log_wr    [0:NLOG-1];
  bit [15:0] log_addr  [0:NLOG-1];
  bit [15:0] log_wdata [0:NLOG-1];
  bit        log_ife   [0:NLOG-1];
  bit        log_dfe   [0:NLOG-1];
  bit [2:0]  log_idx   [0:NLOG-1];
  bit [15:0] log_fdata [0:NLOG-1];
  bit        log_idone [0:NLOG-1];
  bit        log_ddone [0:NLOG-1];
  bit        log_ack   [0:NLOG-1];
  bit        log_busy  [0:NLOG-1];

  function automatic logic [15:0] mdat(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A5A;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory: reads return in order after a per-read latency; inputs are
  // driven just after the rising edge, outputs logged on the falling edge.
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      pend.delete();
      last_rc = 0;
    end
    mem_data_valid = 1'b0;
    mem_rdata      = 16'($urandom);
    if (pend.size() > 0 && pend[0].rc == cyc) begin
      mem_data_valid = 1'b1;
      mem_rdata      = mdat(pend[0].a);
      void'(pend.pop_front());
    end else if (spur_at == cyc) begin
      mem_data_valid = 1'b1;
    end
    @(negedge clk);
    if (cyc < NLOG) begin
      log_en[cyc]    = mem_en;
      log_wr[cyc]    = mem_wr;
      log_addr[cyc]  = mem_addr;
      log_wdata[cyc] = mem_wdata;
      log_ife[cyc]   = i_fill_we;
      log_dfe[cyc]   = d_fill_we;
      log_idx[cyc]   = fill_idx;
      log_fdata[cyc] = fill_data;
      log_idone[cyc] = i_fill_done;
      log_ddone[cyc] = d_fill_done;
      log_ack[cyc]   = d_wr_ack;
      log_busy[cyc]  = busy;
    end
    if (mem_en && !mem_wr && !rst) begin
      int rc;
      rc = cyc + int'($urandom_range(lat_max, lat_min));
      if (rc <= last_rc) rc = last_rc + 1;
      last_rc = rc;
      pend.push_back('{rc, mem_addr});
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic bit d_wins();
`ifdef MEM_ARB_RR_EN
    return !last_d;
`else
    return 1'b1;
`endif
  endfunction

  task automatic check_fill(input bit sd, input logic [15:0] blk,
                            input int t0, output int td);
    int n, tl, oth, bad;
    n = 0; tl = t0; oth = 0; bad = 0;
    for (int k = 0; k < 8; k++)
      chk("fill_issue", {log_en[t0+k], log_wr[t0+k], log_addr[t0+k]},
          {1'b1, 1'b0, blk + 16'(2 * k)});
    for (int c = t0; c <= cyc && c < t0 + 200 && n < 8; c++) begin
      if (sd ? log_ife[c] : log_dfe[c]) oth++;
      if (log_wr[c] || log_idone[c] || log_ddone[c]) bad++;
      if (sd ? log_dfe[c] : log_ife[c]) begin
        chk("fill_word", {log_idx[c], log_fdata[c]},
            {3'(n), mdat(blk + 16'(2 * n))});
        n++;
        tl = c;
      end
    end
    chk("fill_count", n, 8);
    chk("fill_other_side", oth, 0);
    chk("fill_wr_or_done_inside", bad, 0);
    td = tl + 1;
    chk("fill_done", {log_idone[td], log_ddone[td]},
        sd ? 32'd1 : 32'd2);
  endtask

  // Raise requests while idle, hold each until its ack/done, then check
  // the logged traffic against the order implied by the priority rules.
  task automatic run_reqs(input bit ri, input bit rd, input bit rw,
                          input logic [15:0] ai, input logic [15:0] ad,
                          input logic [15:0] aw, input logic [15:0] wd,
                          input int wdel, input bit scr,
                          output int c0, output int tfirst);
    bit pi, pd, pw, lr, mi, md, mw, lw, sd;
    int n, t, td;
    c0 = cyc;
    chk("idle_at_req", log_busy[cyc], 0);
    i_miss_req  = ri; i_miss_addr = ai;
    d_miss_req  = rd; d_miss_addr = ad;
    d_wr_req    = rw && wdel == 0;
    d_wr_addr   = aw; d_wr_data = wd;
    pi = ri; pd = rd; pw = rw; lr = rw && wdel > 0;
    n = 0;
    while ((pi || pd || pw) && n < 400) begin
      tick();
      n++;
      if (lr && cyc == c0 + wdel) begin
        d_wr_req = 1'b1;
        lr = 1'b0;
      end
      if (scr && cyc == c0 + 2) begin
        i_miss_addr = 16'($urandom);
        d_miss_addr = 16'($urandom);
      end
      if (log_ack[cyc]) begin d_wr_req = 1'b0; pw = 1'b0; end
      if (log_ddone[cyc]) begin d_miss_req = 1'b0; pd = 1'b0; end
      if (log_idone[cyc]) begin i_miss_req = 1'b0; pi = 1'b0; end
    end
    chk("run_timeout", {pi, pd, pw}, 0);
    i_miss_req = 1'b0; d_miss_req = 1'b0; d_wr_req = 1'b0;
    tick();
    mi = ri; md = rd; mw = rw && wdel == 0; lw = rw && wdel > 0;
    t = c0 + 1;
    tfirst = -1;
    while (mi || md || mw) begin
      if (mw) begin
        chk("wr_cmd", {log_en[t], log_wr[t], log_ack[t], log_addr[t]},
            {1'b1, 1'b1, 1'b1, aw});
        chk("wr_data", log_wdata[t], wd);
        mw = 1'b0;
        t = t + 2;
      end else begin
        sd = md && (!mi || d_wins());
        if (sd) md = 1'b0; else mi = 1'b0;
        last_d = sd;
        check_fill(sd, (sd ? ad : ai) & 16'hFFF0, t, td);
        if (tfirst < 0) tfirst = td;
        t = td + 2;
      end
      if (lw) begin mw = 1'b1; lw = 1'b0; end
    end
  endtask

  initial begin
    int c0, td, n, found;
    bit [2:0] r;
    bit ri, rd, rw;
    repeat (3) tick();
    chk("rst_strobes", {busy, mem_en, mem_wr, i_fill_we, d_fill_we,
        i_fill_done, d_fill_done, d_wr_ack}, 0);
    chk("rst_bus", {mem_addr, mem_wdata}, 0);
    chk("rst_idx", fill_idx, 0);
    chk("rst_fill_data", fill_data, mem_rdata);
    rst = 1'b0;
    tick();

    run_reqs(1, 0, 0, 16'h1234, 0, 0, 0, 0, 1, c0, td);
    chk("i_done_latency", td - c0, 13);

    run_reqs(1, 1, 0, 16'h0040, 16'h8000, 0, 0, 0, 0, c0, td);
    run_reqs(0, 1, 0, 0, 16'h4440, 0, 0, 0, 0, c0, td);
    run_reqs(1, 1, 0, 16'h0A10, 16'h0B20, 0, 0, 0, 0, c0, td);

    run_reqs(1, 0, 1, 16'h5670, 0, 16'h2002, 16'hBEEF, 3, 0, c0, td);

    run_reqs(0, 1, 0, 0, 16'hFFF8, 0, 0, 0, 0, c0, td);
    chk("top_blk_last_addr", log_addr[c0+8], 16'hFFFE);

    spur_at = cyc + 1;
    tick();
    chk("spurious_valid_idle", {log_ife[cyc], log_dfe[cyc],
        log_busy[cyc]}, 0);

    i_miss_addr = 16'h3000;
    i_miss_req  = 1'b1;
    found = 0;
    n = 0;
    while (!found && n < 40) begin
      tick();
      n++;
      if (log_ife[cyc] && log_idx[cyc] == 3'd4) found = 1;
    end
    chk("reached_5th_word", found, 1);
    rst = 1'b1;
    i_miss_req = 1'b0;
    tick();
    chk("mid_rst_outputs", {busy, mem_en, i_fill_we, d_fill_we,
        i_fill_done, d_fill_done, d_wr_ack}, 0);
    rst = 1'b0;
    last_d = 1'b0;
    n = 0;
    repeat (10) begin
      tick();
      if (log_idone[cyc] || log_ddone[cyc] || log_busy[cyc]) n++;
    end
    chk("no_done_after_rst", n, 0);
    run_reqs(1, 0, 0, 16'h3000, 0, 0, 0, 0, 0, c0, td);

    lat_min = 1;
    lat_max = 6;
    for (int k = 0; k < 25; k++) begin
      r = 3'($urandom_range(7, 1));
      ri = r[0]; rd = r[1]; rw = r[2];
      run_reqs(ri, rd, rw,
               16'($urandom), 16'($urandom),
               16'($urandom), 16'($urandom),
               (rw && (ri || rd) && $urandom_range(1, 0) == 1) ? 3 : 0,
               0, c0, td);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nassert, nfail);
    $finish;
  end

endmodule
